i2s_tx_channel: RTL and testbench



---
 rtl/i2s_tx_channel.sv | 201 ++++++++++++++++++++
 tb/tb_i2s_tx_channel.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_channel.sv
// rtl/i2s_tx_channel.sv - I2S transmit channel: FIFO holding buffer, serializer and WS master
module i2s_tx_channel (
  input  logic        sck_i,
  input  logic        rst_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_data_valid_i,
  output logic        fifo_data_ready_o,
  output logic        fifo_err_o,
  output logic        i2s_ch0_o,
  output logic        i2s_ch1_o,
  output logic        i2s_ws_o,
  input  logic        cfg_en_i,
  input  logic        cfg_2ch_i,
  input  logic [4:0]  cfg_wlen_i,
  input  logic [2:0]  cfg_wnum_i,
  input  logic        cfg_lsb_first_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      s_state_next;

  logic [4:0]  r_count_bit;
  logic [2:0]  r_count_word;
  logic        r_half;
  logic        r_ws;

  logic [31:0] r_buf0;
  logic [31:0] r_buf1;
  logic        r_buf0_valid;
  logic        r_buf1_valid;

  logic [31:0] r_sr0;
  logic [31:0] r_sr1;
  logic        r_ch0;
  logic        r_ch1;
  logic        r_err;

  logic        s_full;
  logic        s_push;
  logic        s_bit_last;
  logic        s_word_last;
  logic        s_ws_toggle;
  logic        s_slot_start;
  logic        s_stop;

  logic [31:0] s_buf0_w;
  logic [31:0] s_buf1_w;
  logic        s_buf0_valid_w;
  logic        s_buf1_valid_w;
  logic        s_full_w;
  logic        s_load;
  logic [31:0] s_load0;
  logic [31:0] s_load1;

  // buf1 only counts towards "full" in dual-line mode
  assign s_full            = r_buf0_valid & (r_buf1_valid | ~cfg_2ch_i);
  assign fifo_data_ready_o = cfg_en_i & ~s_full & ~rst_i;
  assign s_push            = fifo_data_valid_i & fifo_data_ready_o;

  assign s_bit_last  = (r_count_bit == cfg_wlen_i);
  assign s_word_last = (r_count_word == cfg_wnum_i);
  // WS flips one bit ahead of the half-frame boundary (Philips alignment)
  assign s_ws_toggle = (r_state == ST_RUN) & s_word_last & (r_count_bit == (cfg_wlen_i - 5'd1));

  // next state: start on enable, stop only after the last bit of a right half-frame
  always_comb begin
    s_state_next = r_state;
    s_slot_start = 1'b0;
    s_stop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en_i) begin
          s_state_next = ST_RUN;
          s_slot_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (s_bit_last) begin
          if (s_word_last && r_half && !cfg_en_i) begin
            s_state_next = ST_IDLE;
            s_stop       = 1'b1;
          end else begin
            s_slot_start = 1'b1;
          end
        end
      end
      default: s_state_next = ST_IDLE;
    endcase
  end

  // buffer contents after this cycle's handshake, so a word accepted on the slot-start edge is used
  always_comb begin
    s_buf0_w       = r_buf0;
    s_buf1_w       = r_buf1;
    s_buf0_valid_w = r_buf0_valid;
    s_buf1_valid_w = r_buf1_valid;
    if (s_push) begin
      if (!r_buf0_valid) begin
        s_buf0_w       = fifo_data_i;
        s_buf0_valid_w = 1'b1;
      end else begin
        s_buf1_w       = fifo_data_i;
        s_buf1_valid_w = 1'b1;
      end
    end
  end

  assign s_full_w = s_buf0_valid_w & (s_buf1_valid_w | ~cfg_2ch_i);
  assign s_load   = s_slot_start & s_full_w;
  assign s_load0  = s_load ? s_buf0_w : 32'd0;
  assign s_load1  = (s_load & cfg_2ch_i) ? s_buf1_w : 32'd0;

  // state register
  always_ff @(posedge sck_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= s_state_next;
  end

  // bit/word counters; the stop edge wraps both, so IDLE always holds them at zero
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_count_bit  <= 5'd0;
      r_count_word <= 3'd0;
    end else if (r_state == ST_RUN) begin
      if (s_bit_last) begin
        r_count_bit  <= 5'd0;
        r_count_word <= s_word_last ? 3'd0 : r_count_word + 3'd1;
      end else begin
        r_count_bit  <= r_count_bit + 5'd1;
      end
    end
  end

  // data half-frame tracker and the WS output register that leads it by one bit
  always_ff @(posedge sck_i) begin
    if (rst_i || s_stop) begin
      r_half <= 1'b0;
      r_ws   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (s_bit_last && s_word_last) r_half <= ~r_half;
      if (s_ws_toggle)               r_ws   <= ~r_ws;
    end
  end

  // holding buffer: fill on handshake, drain into the shift registers at a full slot start
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_buf0       <= 32'd0;
      r_buf1       <= 32'd0;
      r_buf0_valid <= 1'b0;
      r_buf1_valid <= 1'b0;
    end else begin
      r_buf0       <= s_buf0_w;
      r_buf1       <= s_buf1_w;
      r_buf0_valid <= s_buf0_valid_w & ~s_load;
      r_buf1_valid <= s_buf1_valid_w & ~s_load;
    end
  end

  // serializer: the first bit goes straight to the output flop, the rest follow from the shifter
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_sr0 <= 32'd0;
      r_sr1 <= 32'd0;
      r_ch0 <= 1'b0;
      r_ch1 <= 1'b0;
    end else if (s_slot_start) begin
      r_ch0 <= cfg_lsb_first_i ? s_load0[0] : s_load0[cfg_wlen_i];
      r_ch1 <= cfg_lsb_first_i ? s_load1[0] : s_load1[cfg_wlen_i];
      r_sr0 <= cfg_lsb_first_i ? (s_load0 >> 1) : (s_load0 << 1);
      r_sr1 <= cfg_lsb_first_i ? (s_load1 >> 1) : (s_load1 << 1);
    end else if (r_state == ST_RUN && !s_stop) begin
      r_ch0 <= cfg_lsb_first_i ? r_sr0[0] : r_sr0[cfg_wlen_i];
      r_ch1 <= cfg_2ch_i & (cfg_lsb_first_i ? r_sr1[0] : r_sr1[cfg_wlen_i]);
      r_sr0 <= cfg_lsb_first_i ? (r_sr0 >> 1) : (r_sr0 << 1);
      r_sr1 <= cfg_lsb_first_i ? (r_sr1 >> 1) : (r_sr1 << 1);
    end else begin
      r_sr0 <= 32'd0;
      r_sr1 <= 32'd0;
      r_ch0 <= 1'b0;
      r_ch1 <= 1'b0;
    end
  end

  // underrun flag, high for the first bit of a slot that started with a short buffer
  always_ff @(posedge sck_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= s_slot_start & ~s_full_w;
  end

  assign fifo_err_o = r_err;
  assign i2s_ch0_o  = r_ch0;
  assign i2s_ch1_o  = r_ch1;
  assign i2s_ws_o   = r_ws;

endmodule

// File: tb/tb_i2s_tx_channel.sv
// tb/tb_i2s_tx_channel.sv - directed vector bench for i2s_tx_channel
module tb_i2s_tx_channel;

  logic        sck = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic        err;
  logic        ch0;
  logic        ch1;
  logic        ws;
  logic        en = 1'b0;
  logic        c2ch = 1'b0;
  logic [4:0]  wlen = 5'd15;
  logic [2:0]  wnum = 3'd0;
  logic        lsb = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        valid;
    logic [31:0] data;
    logic        ch0;
    logic        ch1;
    logic        ws;
    logic        ready;
    logic        err;
  } vec_t;

  vec_t vt[$];

  i2s_tx_channel dut (
    .sck_i             (sck),
    .rst_i             (rst),
    .fifo_data_i       (data),
    .fifo_data_valid_i (valid),
    .fifo_data_ready_o (ready),
    .fifo_err_o        (err),
    .i2s_ch0_o         (ch0),
    .i2s_ch1_o         (ch1),
    .i2s_ws_o          (ws),
    .cfg_en_i          (en),
    .cfg_2ch_i         (c2ch),
    .cfg_wlen_i        (wlen),
    .cfg_wnum_i        (wnum),
    .cfg_lsb_first_i   (lsb)
  );

  always #5 sck = ~sck;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sck);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b0;
    valid = 1'b0;
    data  = 32'd0;
    step();
    rst   = 1'b0;
  endtask

  function automatic void add(input int e, input int v, input logic [31:0] d,
                              input int o0, input int o1, input int w, input int r, input int x);
    vec_t t;
    t.en    = (e != 0);
    t.valid = (v != 0);
    t.data  = d;
    t.ch0   = (o0 != 0);
    t.ch1   = (o1 != 0);
    t.ws    = (w != 0);
    t.ready = (r != 0);
    t.err   = (x != 0);
    vt.push_back(t);
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < vt.size(); i++) begin
      en    = vt[i].en;
      valid = vt[i].valid;
      data  = vt[i].data;
      #1;
      check($sformatf("%s c%0d ch0", tag, i), ch0, vt[i].ch0);
      check($sformatf("%s c%0d ch1", tag, i), ch1, vt[i].ch1);
      check($sformatf("%s c%0d ws", tag, i), ws, vt[i].ws);
      check($sformatf("%s c%0d ready", tag, i), ready, vt[i].ready);
      check($sformatf("%s c%0d err", tag, i), err, vt[i].err);
      step();
    end
    vt.delete();
  endtask

  initial begin
    logic [15:0] pat16;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  pat8;
    logic [3:0]  pat4;
    int          pulses;

    do_reset();
    #1;
    check("reset ch0", ch0, 1'b0);
    check("reset ch1", ch1, 1'b0);
    check("reset ws", ws, 1'b0);
    check("reset ready", ready, 1'b0);
    check("reset err", err, 1'b0);

    // mono, MSB first, 16-bit word 0xA5C3 handed over on the enable edge
    wlen = 5'd15; wnum = 3'd0; c2ch = 1'b0; lsb = 1'b0;
    pat16 = 16'b1010_0101_1100_0011;
    add(1, 1, 32'h0000_A5C3, 0, 0, 0, 1, 0);
    for (int b = 15; b >= 0; b--) add(1, 0, 32'd0, int'(pat16[b]), 0, (b == 0) ? 1 : 0, 1, 0);
    add(1, 0, 32'd0, 0, 0, 1, 1, 1);
    run_table("mono");

    // dual line, LSB first, 8-bit words; first slot underruns, words pushed during it
    do_reset();
    wlen = 5'd7; wnum = 3'd0; c2ch = 1'b1; lsb = 1'b1;
    e0 = 8'b1000_0001;
    e1 = 8'b0011_1100;
    add(1, 0, 32'd0,  0, 0, 0, 1, 0);
    add(1, 1, 32'h81, 0, 0, 0, 1, 1);
    add(1, 1, 32'h3C, 0, 0, 0, 1, 0);
    for (int c = 3; c <= 7; c++) add(1, 0, 32'd0, 0, 0, 0, 0, 0);
    add(1, 0, 32'd0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) add(1, 0, 32'd0, int'(e0[7-k]), int'(e1[7-k]), (k < 7) ? 1 : 0, 1, 0);
    add(1, 0, 32'd0, 0, 0, 0, 1, 1);
    run_table("dual");

    // underrun: enable empty, word 0xB6 offered from cycle 4 and kept valid
    do_reset();
    wlen = 5'd7; wnum = 3'd0; c2ch = 1'b0; lsb = 1'b0;
    pat8 = 8'b1011_0110;
    en = 1'b1;
    step();
    pulses = 0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 4) begin
        valid = 1'b1;
        data  = 32'h0000_00B6;
      end
      #1;
      if (c <= 8) begin
        check($sformatf("underrun slot0 ch0 c%0d", c), ch0, 1'b0);
        check($sformatf("underrun slot0 err c%0d", c), err, (c == 1));
      end else begin
        check($sformatf("underrun data ch0 c%0d", c), ch0, pat8[7 - ((c - 9) % 8)]);
        if (err) pulses++;
      end
      step();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL underrun later err pulses: got %0d expected 0", pulses);
    end

    // WS framing: 4-bit words, 3 words per half-frame
    do_reset();
    wlen = 5'd3; wnum = 3'd2; c2ch = 1'b0; lsb = 1'b0;
    en = 1'b1; valid = 1'b1; data = 32'd0;
    step();
    for (int c = 1; c <= 60; c++) begin
      check($sformatf("ws frame c%0d", c), ws, (((c / 12) % 2) == 1));
      step();
    end

    // disable in the left half-frame: frame completes, then IDLE
    do_reset();
    wlen = 5'd3; wnum = 3'd2; c2ch = 1'b0; lsb = 1'b0;
    en = 1'b1; valid = 1'b1; data = 32'h0000_000A;
    pat4 = 4'b1010;
    step();
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) en = 1'b0;
      #1;
      if (c == 5) check("disable ready drop", ready, 1'b0);
      if (c >= 5 && c <= 8) check($sformatf("disable slot1 ch0 c%0d", c), ch0, pat4[8 - c]);
      if (c == 21) check("disable last slot err", err, 1'b1);
      if (c <= 24) check($sformatf("disable ws c%0d", c), ws, (c >= 12 && c <= 23));
      if (c >= 25) begin
        check($sformatf("disable idle ch0 c%0d", c), ch0, 1'b0);
        check($sformatf("disable idle ws c%0d", c), ws, 1'b0);
        check($sformatf("disable idle err c%0d", c), err, 1'b0);
        check($sformatf("disable idle ready c%0d", c), ready, 1'b0);
      end
      step();
    end

    // synchronous reset in the right half-frame, then restart
    do_reset();
    wlen = 5'd7; wnum = 3'd0; c2ch = 1'b0; lsb = 1'b0;
    en = 1'b1; valid = 1'b1; data = 32'h0000_00FF;
    step();
    for (int c = 1; c < 10; c++) step();
    check("rst pre ws", ws, 1'b1);
    check("rst pre ch0", ch0, 1'b1);
    rst = 1'b1;
    step();
    check("rst ch0", ch0, 1'b0);
    check("rst ch1", ch1, 1'b0);
    check("rst ws", ws, 1'b0);
    check("rst err", err, 1'b0);
    check("rst ready", ready, 1'b0);
    rst = 1'b0;
    step();
    check("restart ch0", ch0, 1'b1);
    check("restart err", err, 1'b0);
    check("restart ws c1", ws, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      step();
      check($sformatf("restart ws c%0d", c), ws, (c == 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
